uart_tx: RTL

- Parameterised UART transmitter, 8× oversampled; the transmit-side counterpart of the team's 8× oversampling receiver.
- Serialises one byte per frame onto the idle-high line `tx`, LSB first, with optional odd/even parity and 1 or 2 stop bits.
- Uses the same external `bd8_rate` enable (one `clk` pulse per 1/8 bit period), so a matched pair interoperates at identical settings.
- Sits between a byte-producing client (valid/ready handshake) and the pad.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the 8x-oversampled transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP1,
      S_STOP2
   } uart_state_e;

   localparam int    TICKS_PER_BIT = 8;
   localparam string PAR_ODD       = "ODD";
   localparam string PAR_EVEN      = "EVEN";

   // odd = 1 makes the total count of ones (data + parity) odd
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8x-oversampled UART transmitter: one byte per frame, LSB first, optional parity,
// 1 or 2 stop bits, advancing only on the external bd8_rate enable.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// ARMED  | byte latched, waiting for the next bd8_rate to open the start bit
// START  | start bit (tx = 0)
// DATA   | data bits, LSB first (tx = shift[0])
// PAR    | parity bit
// STOP1  | first stop bit (tx = 1)
// STOP2  | second stop bit when two are configured
module uart_tx
   import uart_pkg::*;
#(
   parameter string PARITY   = "ODD",
   parameter int    STOP_BIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bd8_rate,
   input  logic [7:0] tx_data,
   input  logic       tx_vld,
   output logic       tx_rdy,
   output logic       tx,
   output logic       tx_done
);

   localparam logic       PAR_EN    = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
   localparam logic       PAR_IS_ODD = (PARITY == PAR_ODD);
   localparam logic       TWO_STOP  = (STOP_BIT == 2);
   localparam logic [2:0] TICK_LAST = 3'(TICKS_PER_BIT - 1);

   uart_state_e state_q, state_d;
   logic [2:0]  tick_cnt_q, tick_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic        tx_done_q, tx_done_d;
   logic        in_bit;
   logic        bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= 3'd0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'd0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_done_d  = 1'b0;

      in_bit  = (state_q != S_IDLE) && (state_q != S_ARMED);
      bit_end = in_bit && bd8_rate && (tick_cnt_q == TICK_LAST);

      // tick_cnt wraps 7->0 on its own, so every bit period restarts at zero
      if (in_bit && bd8_rate) begin
         tick_cnt_d = tick_cnt_q + 3'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (tx_vld) begin
               state_d = S_ARMED;
               shift_d = tx_data;
               par_d   = parity_bit(tx_data, PAR_IS_ODD);
            end
         end
         S_ARMED: begin
            if (bd8_rate) begin
               state_d    = S_START;
               tick_cnt_d = 3'd0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = PAR_EN ? S_PAR : S_STOP1;
               end
            end
         end
         S_PAR: begin
            if (bit_end) begin
               state_d = S_STOP1;
            end
         end
         S_STOP1: begin
            if (bit_end) begin
               if (TWO_STOP) begin
                  state_d = S_STOP2;
               end else begin
                  state_d   = S_IDLE;
                  tx_done_d = 1'b1;
               end
            end
         end
         S_STOP2: begin
            if (bit_end) begin
               state_d   = S_IDLE;
               tx_done_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // line level follows the state being entered, so tx only moves on bd8_rate edges
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         S_PAR:   tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   assign tx_rdy  = (state_q == S_IDLE);
   assign tx      = tx_q;
   assign tx_done = tx_done_q;

endmodule
